// File: rtl/gf180mcu_osu_sc_gp12t3v3__nandn_bist.sv
// rtl/gf180mcu_osu_sc_gp12t3v3__nandn_bist.sv - self-test sequencer for N-input NAND gate instances
//
// Purpose: drives one input vector per cycle onto CHANNELS NAND gates. It predicts ~&A for
// each channel and compares the returned Y after LAT cycles. At the end of a sweep it reports
// a saturating error count, a sticky per-channel fail mask and pass/fail.
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   START, MODE     begin a sweep (IDLE/DONE only); 0 = exhaustive, 1 = walking-zero
//   A               gate inputs, channel c on A[c*N_IN +: N_IN]
//   Y               gate outputs returned from the checked cells
//   BUSY, DONE      sweep in progress / results valid
//   PASS            DONE with zero mismatches
//   ERR_CNT         total mismatches, saturating
//   FAIL_MASK       sticky per-channel mismatch flags
module gf180mcu_osu_sc_gp12t3v3__nandn_bist #(
  parameter int N_IN     = 2,
  parameter int CHANNELS = 4,
  parameter int LAT      = 1,
  parameter int ERR_W    = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       MODE,
  output logic [CHANNELS*N_IN-1:0]   A,
  input  logic [CHANNELS-1:0]        Y,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       PASS,
  output logic [ERR_W-1:0]           ERR_CNT,
  output logic [CHANNELS-1:0]        FAIL_MASK
);

  // idx must reach 2^N_IN (one past the last exhaustive vector)
  localparam int IW = N_IN + 1;
  // headroom so a full cycle of mismatches can be added before clamping
  localparam int SW = ERR_W + 5;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic          mode_q;
  logic [IW-1:0] idx;
  logic [1:0]    drain_cnt;

  function automatic logic [N_IN-1:0] vec_at(input logic [IW-1:0] i, input logic m);
    logic [N_IN-1:0] v;
    if (!m) begin
      v = i[N_IN-1:0];
    end else begin
      v = '1;
      for (int k = 0; k < N_IN; k++)
        if (i == IW'(k + 1)) v[k] = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [IW-1:0] vec_count(input logic m);
    return m ? IW'(N_IN + 1) : IW'(1 << N_IN);
  endfunction

  // channel c gets the vector rotated left by c mod N_IN
  function automatic logic [CHANNELS*N_IN-1:0] spread(input logic [N_IN-1:0] v);
    logic [CHANNELS*N_IN-1:0] a;
    a = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int i = 0; i < N_IN; i++)
        a[c*N_IN + (i + c % N_IN) % N_IN] = v[i];
    return a;
  endfunction

  logic [CHANNELS-1:0] exp_now;
  logic [CHANNELS-1:0] cmp_exp;
  logic                cmp_valid;
  logic [CHANNELS-1:0] mism;
  logic [SW-1:0]       sum;
  logic [ERR_W-1:0]    err_next;
  logic [CHANNELS-1:0] mask_next;

  always_comb begin
    exp_now = '0;
    for (int c = 0; c < CHANNELS; c++)
      exp_now[c] = ~&A[c*N_IN +: N_IN];
  end

  generate
    if (LAT == 0) begin : g_comb
      // combinational cell: Y reflects the A currently being driven
      assign cmp_valid = (state == S_DRIVE);
      assign cmp_exp   = exp_now;
    end else begin : g_pipe
      localparam int PD = LAT;
      logic [PD-1:0]       pv;
      logic [CHANNELS-1:0] pe [PD];

      always_ff @(posedge CLK) begin
        if (RST) begin
          pv <= '0;
          for (int i = 0; i < PD; i++) pe[i] <= '0;
        end else begin
          pv[0] <= (state == S_DRIVE);
          pe[0] <= exp_now;
          for (int i = 1; i < PD; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
          end
        end
      end

      assign cmp_valid = pv[PD-1];
      assign cmp_exp   = pe[PD-1];
    end
  endgenerate

  // case inequality so an unknown Y is never silently accepted
  always_comb begin
    mism      = '0;
    sum       = SW'(ERR_CNT);
    err_next  = ERR_CNT;
    mask_next = FAIL_MASK;
    for (int c = 0; c < CHANNELS; c++) begin
      mism[c] = cmp_valid && (Y[c] !== cmp_exp[c]);
      sum     = sum + SW'(mism[c]);
    end
    if (cmp_valid) begin
      err_next  = (|sum[SW-1:ERR_W]) ? '1 : sum[ERR_W-1:0];
      mask_next = FAIL_MASK | mism;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      idx       <= '0;
      drain_cnt <= '0;
      A         <= '1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= '0;
      FAIL_MASK <= '0;
    end else begin
      ERR_CNT   <= err_next;
      FAIL_MASK <= mask_next;
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state     <= S_DRIVE;
            mode_q    <= MODE;
            A         <= spread(vec_at(IW'(0), MODE));
            idx       <= IW'(1);
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= '0;
            FAIL_MASK <= '0;
          end
        end
        S_DRIVE: begin
          if (idx == vec_count(mode_q)) begin
            A <= '1;
            if (LAT == 0) begin
              // last compare lands on this same edge, so PASS uses err_next
              state <= S_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              PASS  <= (err_next == '0);
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= 2'(LAT - 1);
            end
          end else begin
            A   <= spread(vec_at(idx, mode_q));
            idx <= idx + IW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__nandn_bist.sv
// tb/tb_gf180mcu_osu_sc_gp12t3v3__nandn_bist.sv - self-checking bench for the NAND BIST sequencer
module tb_gf180mcu_osu_sc_gp12t3v3__nandn_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mode;

  // inst 0: N_IN=2 CHANNELS=4 LAT=1 ERR_W=8
  logic [7:0]  a0;  logic [3:0] y0, mask0;  logic busy0, done0, pass0;  logic [7:0] err0;
  // inst 1: N_IN=4 CHANNELS=1 LAT=0 ERR_W=8
  logic [3:0]  a1;  logic [0:0] y1, mask1;  logic busy1, done1, pass1;  logic [7:0] err1;
  // inst 2: N_IN=3 CHANNELS=4 LAT=2 ERR_W=2
  logic [11:0] a2;  logic [3:0] y2, y2_d, mask2;  logic busy2, done2, pass2;  logic [1:0] err2;

  // per-channel fault: 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
  int f0[4], f1[4], f2[4];
  int ncmp = 0;
  int nfail = 0;

  gf180mcu_osu_sc_gp12t3v3__nandn_bist #(.N_IN(2), .CHANNELS(4), .LAT(1), .ERR_W(8)) dut0 (
    .CLK(clk), .RST(rst), .START(start), .MODE(mode), .A(a0), .Y(y0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0), .FAIL_MASK(mask0));
  gf180mcu_osu_sc_gp12t3v3__nandn_bist #(.N_IN(4), .CHANNELS(1), .LAT(0), .ERR_W(8)) dut1 (
    .CLK(clk), .RST(rst), .START(start), .MODE(mode), .A(a1), .Y(y1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1), .FAIL_MASK(mask1));
  gf180mcu_osu_sc_gp12t3v3__nandn_bist #(.N_IN(3), .CHANNELS(4), .LAT(2), .ERR_W(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start), .MODE(mode), .A(a2), .Y(y2),
    .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err2), .FAIL_MASK(mask2));

  function automatic logic fy(input int f, input logic ideal);
    case (f)
      0:       return ideal;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ~ideal;
    endcase
  endfunction

  // gate models with the latency each instance is configured for
  always @(posedge clk)
    for (int c = 0; c < 4; c++) y0[c] <= fy(f0[c], ~&a0[c*2 +: 2]);
  always_comb y1[0] = fy(f1[0], ~&a1);
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) y2_d[c] <= fy(f2[c], ~&a2[c*3 +: 3]);
    y2 <= y2_d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int vec(input int n, input int m, input int j);
    int all;
    all = (1 << n) - 1;
    if (m == 0) return j;
    return (j == 0) ? all : (all & ~(1 << (j - 1)));
  endfunction

  function automatic int aword(input int n, input int ch, input int v);
    int w, k, all;
    w = 0;
    all = (1 << n) - 1;
    for (int c = 0; c < ch; c++) begin
      k = c % n;
      w |= (((v << k) | (v >> (n - k))) & all) << (c * n);
    end
    return w;
  endfunction

  // NAND of any rotation is 0 only for the all-ones vector, and each sweep has exactly one
  function automatic int ch_err(input int n, input int m, input int f);
    int nv;
    nv = m ? (n + 1) : (1 << n);
    case (f)
      0:       return 0;
      1:       return nv - 1;
      2:       return 1;
      default: return nv;
    endcase
  endfunction

  task automatic sweep(input int m, input bit glitch);
    int b0, b1, b2, t0, t1, t2, mk0, mk1, mk2, e, n0, n1, n2;
    bit fin;
    b0 = 0; b1 = 0; b2 = 0; t0 = 0; t1 = 0; t2 = 0; mk0 = 0; mk1 = 0; mk2 = 0; fin = 0;
    n0 = m ? 3 : 4;  n1 = m ? 5 : 16;  n2 = m ? 4 : 8;
    for (int c = 0; c < 4; c++) begin
      e = ch_err(2, m, f0[c]); t0 += e; if (e != 0) mk0 |= 1 << c;
      e = ch_err(3, m, f2[c]); t2 += e; if (e != 0) mk2 |= 1 << c;
    end
    t1 = ch_err(4, m, f1[0]); mk1 = (t1 != 0) ? 1 : 0;
    if (t0 > 255) t0 = 255;
    if (t1 > 255) t1 = 255;
    if (t2 > 3) t2 = 3;

    @(negedge clk); start = 1'b1; mode = m[0];
    @(negedge clk); start = 1'b0;
    check("clr_done", 32'(done0 | done1 | done2), 0);
    check("clr_err0", 32'(err0), 0);
    check("clr_mask2", 32'(mask2), 0);
    for (int cyc = 0; cyc < 64; cyc++) begin
      start = (glitch && cyc == 2);
      if (busy0) begin check("a0_vec", 32'(a0), aword(2, 4, b0 < n0 ? vec(2, m, b0) : 3)); b0++; end
      if (busy1) begin check("a1_vec", 32'(a1), aword(4, 1, b1 < n1 ? vec(4, m, b1) : 15)); b1++; end
      if (busy2) begin check("a2_vec", 32'(a2), aword(3, 4, b2 < n2 ? vec(3, m, b2) : 7)); b2++; end
      if (!(busy0 || busy1 || busy2)) begin fin = 1'b1; break; end
      @(negedge clk);
    end
    start = 1'b0;
    check("sweep_end", 32'(fin), 1);
    check("busy0_len", b0, n0 + 1);
    check("busy1_len", b1, n1);
    check("busy2_len", b2, n2 + 2);
    repeat (3) @(negedge clk);
    check("done_all", 32'({done0, done1, done2}), 7);
    check("err0", 32'(err0), t0);   check("mask0", 32'(mask0), mk0);  check("pass0", 32'(pass0), t0 == 0);
    check("err1", 32'(err1), t1);   check("mask1", 32'(mask1), mk1);  check("pass1", 32'(pass1), t1 == 0);
    check("err2", 32'(err2), t2);   check("mask2", 32'(mask2), mk2);  check("pass2", 32'(pass2), t2 == 0);
    check("a_idle", 32'({a0, a1, a2}), 32'hFFFFFF);
  endtask

  task automatic set_faults(input int v0, input int v1, input int v2);
    for (int c = 0; c < 4; c++) begin f0[c] = v0; f1[c] = v1; f2[c] = v2; end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ctl"}, 32'({busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2}), 0);
    check({tag, "_err"}, 32'({err0, err1, err2}), 0);
    check({tag, "_mask"}, 32'({mask0, mask1, mask2}), 0);
    check({tag, "_a"}, 32'({a0, a1, a2}), 32'hFFFFFF);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    set_faults(0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");

    // ideal cells, exhaustive
    sweep(0, 1'b0);
    // channel 2 of inst 0 stuck-at-1
    f0[2] = 2;
    sweep(0, 1'b0);
    // walking-zero on ideal cells
    set_faults(0, 0, 0);
    sweep(1, 1'b0);
    // every compare wrong: narrow counter saturates
    set_faults(0, 0, 3);
    sweep(0, 1'b0);
    // START during BUSY ignored, then restart from DONE
    set_faults(0, 0, 0);
    sweep(0, 1'b1);
    sweep(0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) begin
        f0[c] = $urandom_range(0, 3);
        f1[c] = $urandom_range(0, 3);
        f2[c] = $urandom_range(0, 3);
      end
      sweep($urandom_range(0, 1), 1'b0);
    end

    // reset on the third DRIVE cycle; pending compares must be discarded
    set_faults(3, 3, 3);
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_cleared("midrst");
    repeat (6) @(negedge clk);
    check_cleared("midrst_late");

    // START and RST on the same edge
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    check_cleared("rst_start");
    @(negedge clk);
    check("rst_start_idle", 32'({busy0, busy1, busy2}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
